// File: rtl/closest_hit.sv
// closest_hit: per-ray nearest-hit reducer.
// Takes one intersection distance per scene object, in object order, and
// tracks the smallest valid positive distance seen so far. After the last
// object of a ray it presents distance, object index and miss flag, then
// holds that result until the shader stage takes it.
module closest_hit #(
    parameter int unsigned     SIZE    = 32,
    parameter int unsigned     NUM_OBJ = 16,
    parameter int unsigned     IDX_W   = $clog2(NUM_OBJ),
    parameter logic [SIZE-1:0] T_MIN   = 32'h3a83126f
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [SIZE-1:0]  t_axis_tdata,
    input  logic             undef_axis_tdata,
    input  logic             t_axis_tvalid,
    output logic             t_axis_tready,
    output logic [SIZE-1:0]  hit_axis_tdata,
    output logic [IDX_W-1:0] hit_axis_obj,
    output logic             hit_axis_miss,
    output logic             hit_axis_tvalid,
    input  logic             hit_axis_tready
);

    localparam logic [1:0] RST_WAIT = 2'd0;
    localparam logic [1:0] ACCUM    = 2'd1;
    localparam logic [1:0] EMIT     = 2'd2;

    // Magnitude of +inf; the sign bit is implicit since only positive
    // distances are ever kept.
    localparam logic [SIZE-2:0]  INF_MAG  = {{8{1'b1}}, {(SIZE-9){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [SIZE-2:0]  best_t_q, best_t_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             have_hit_q, have_hit_d;
    logic [SIZE-2:0]  res_t_q, res_t_d;
    logic [IDX_W-1:0] res_obj_q, res_obj_d;
    logic             res_miss_q, res_miss_d;

    logic [SIZE-2:0]  t_mag;
    logic             is_cand;
    logic             take;
    logic [SIZE-2:0]  sel_t;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_hit;

    // Candidate qualification and running-best selection for the current beat.
    // Positive IEEE floats order the same as their magnitude bits read as
    // unsigned integers, so no FP comparator is needed.
    always_comb begin
        t_mag   = t_axis_tdata[SIZE-2:0];
        is_cand = !undef_axis_tdata
                  && !t_axis_tdata[SIZE-1]
                  && (t_axis_tdata[SIZE-2:SIZE-9] != '1)
                  && (t_mag > T_MIN[SIZE-2:0]);
        // Strict less-than: on a tie the earlier (lower index) object stays.
        take    = is_cand && (!have_hit_q || (t_mag < best_t_q));
        sel_t   = take ? t_mag : best_t_q;
        sel_idx = take ? cnt_q : best_idx_q;
        sel_hit = take || have_hit_q;
    end

    // Next-state logic: accumulate in ACCUM, latch the result on the last
    // beat, hold it in EMIT until the consumer handshakes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_t_d   = best_t_q;
        best_idx_d = best_idx_q;
        have_hit_d = have_hit_q;
        res_t_d    = res_t_q;
        res_obj_d  = res_obj_q;
        res_miss_d = res_miss_q;
        case (state_q)
            RST_WAIT: state_d = ACCUM;
            ACCUM: begin
                if (t_axis_tvalid) begin
                    best_t_d   = sel_t;
                    best_idx_d = sel_idx;
                    have_hit_d = sel_hit;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d      = '0;
                        state_d    = EMIT;
                        res_t_d    = sel_hit ? sel_t : INF_MAG;
                        res_obj_d  = sel_hit ? sel_idx : '0;
                        res_miss_d = !sel_hit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (hit_axis_tready) begin
                    state_d    = ACCUM;
                    best_t_d   = INF_MAG;
                    best_idx_d = '0;
                    have_hit_d = 1'b0;
                end
            end
            default: state_d = RST_WAIT;
        endcase
    end

    // State and data registers; reset discards any partial ray.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= RST_WAIT;
            cnt_q      <= '0;
            best_t_q   <= INF_MAG;
            best_idx_q <= '0;
            have_hit_q <= 1'b0;
            res_t_q    <= INF_MAG;
            res_obj_q  <= '0;
            res_miss_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_t_q   <= best_t_d;
            best_idx_q <= best_idx_d;
            have_hit_q <= have_hit_d;
            res_t_q    <= res_t_d;
            res_obj_q  <= res_obj_d;
            res_miss_q <= res_miss_d;
        end
    end

    assign t_axis_tready   = (state_q == ACCUM);
    assign hit_axis_tvalid = (state_q == EMIT);
    assign hit_axis_tdata  = {1'b0, res_t_q};
    assign hit_axis_obj    = res_obj_q;
    assign hit_axis_miss   = res_miss_q;

endmodule

// File: tb/tb_closest_hit.sv
// tb_closest_hit: directed and randomised vectors for closest_hit with
// four objects per ray; a reference model predicts every ray's result.
module tb_closest_hit;

    localparam int unsigned NOBJ  = 4;
    localparam int unsigned IW    = 2;
    localparam logic [31:0] TMIN  = 32'h3a83126f;
    localparam logic [31:0] PINF  = 32'h7f800000;

    typedef struct packed {
        logic [31:0]   t;
        logic [IW-1:0] obj;
        logic          miss;
    } res_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [31:0]   t_axis_tdata;
    logic          undef_axis_tdata;
    logic          t_axis_tvalid;
    logic          t_axis_tready;
    logic [31:0]   hit_axis_tdata;
    logic [IW-1:0] hit_axis_obj;
    logic          hit_axis_miss;
    logic          hit_axis_tvalid;
    logic          hit_axis_tready;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    res_t        expq[$];
    logic [31:0] mt[NOBJ];
    logic        mu[NOBJ];
    int unsigned nbeat = 0;

    closest_hit #(
        .SIZE    (32),
        .NUM_OBJ (NOBJ),
        .T_MIN   (TMIN)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .t_axis_tdata     (t_axis_tdata),
        .undef_axis_tdata (undef_axis_tdata),
        .t_axis_tvalid    (t_axis_tvalid),
        .t_axis_tready    (t_axis_tready),
        .hit_axis_tdata   (hit_axis_tdata),
        .hit_axis_obj     (hit_axis_obj),
        .hit_axis_miss    (hit_axis_miss),
        .hit_axis_tvalid  (hit_axis_tvalid),
        .hit_axis_tready  (hit_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Reference: nearest positive finite distance strictly above T_MIN,
    // earliest object wins ties.
    function automatic res_t model();
        res_t r;
        logic found;
        logic [31:0] best;
        int unsigned bi;
        found = 1'b0; best = PINF; bi = 0;
        for (int unsigned i = 0; i < NOBJ; i++) begin
            logic ok;
            ok = !mu[i] && (mt[i][31] == 1'b0) && (mt[i][30:23] != 8'hff)
                 && (mt[i][30:0] > TMIN[30:0]);
            if (ok && (!found || mt[i][30:0] < best[30:0])) begin
                found = 1'b1; best = mt[i]; bi = i;
            end
        end
        r.t    = found ? best : PINF;
        r.obj  = found ? IW'(bi) : '0;
        r.miss = !found;
        return r;
    endfunction

    // Compare process: tracks accepted beats, predicts results, checks the
    // presented result every cycle it is valid and retires it on handshake.
    always @(negedge aclk) begin
        if (!aresetn) begin
            nbeat = 0;
        end else begin
            if (hit_axis_tvalid) begin
                if (expq.size() == 0) begin
                    chk("spurious_result", 32'd1, 32'd0);
                end else begin
                    chk("res_tdata", hit_axis_tdata, expq[0].t);
                    chk("res_obj", 32'(hit_axis_obj), 32'(expq[0].obj));
                    chk("res_miss", 32'(hit_axis_miss), 32'(expq[0].miss));
                    if (hit_axis_tready) void'(expq.pop_front());
                end
            end
            if (t_axis_tvalid && t_axis_tready) begin
                mt[nbeat] = t_axis_tdata;
                mu[nbeat] = undef_axis_tdata;
                nbeat++;
                if (nbeat == NOBJ) begin
                    expq.push_back(model());
                    nbeat = 0;
                end
            end
        end
    end

    // All driver tasks begin and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [31:0] t, input logic u, input int unsigned gap);
        logic ok;
        int unsigned n;
        t_axis_tvalid = 1'b0;
        repeat (gap) begin @(posedge aclk); #1; end
        t_axis_tdata = t; undef_axis_tdata = u; t_axis_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk); ok = t_axis_tready;
            @(posedge aclk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) chk("beat_accept_timeout", 32'd0, 32'd1);
        t_axis_tvalid = 1'b0;
    endtask

    task automatic send_ray(input logic [127:0] ts, input logic [3:0] us);
        for (int unsigned i = 0; i < NOBJ; i++)
            send_beat(ts[32*i +: 32], us[i], 0);
    endtask

    task automatic check_result(input string nm, input logic [31:0] t, input logic [IW-1:0] o, input logic m);
        chk({nm, "_tvalid"}, 32'(hit_axis_tvalid), 32'd1);
        chk({nm, "_tdata"}, hit_axis_tdata, t);
        chk({nm, "_obj"}, 32'(hit_axis_obj), 32'(o));
        chk({nm, "_miss"}, 32'(hit_axis_miss), 32'(m));
        chk({nm, "_in_stall"}, 32'(t_axis_tready), 32'd0);
    endtask

    task automatic wait_drain(input string nm);
        int unsigned n;
        n = 0;
        while ((expq.size() != 0 || hit_axis_tvalid) && n < 50) begin
            @(posedge aclk); #1; n++;
        end
        chk(nm, 32'(expq.size()), 32'd0);
    endtask

    localparam logic [127:0] RAY_BASIC = {32'h3f800000, 32'h0, 32'h3f000000, 32'h40000000};
    localparam logic [127:0] RAY_REJ   = {32'h7f800000, 32'h3a03126f, 32'hbf800000, 32'h3f000000};
    localparam logic [127:0] RAY_TIE   = {32'h40400000, TMIN, 32'h3f800000, 32'h3f800000};
    localparam logic [127:0] RAY_RST   = {32'h3f000000, 32'h40000000, 32'h3f800000, 32'h3e800000};

    initial begin
        logic [127:0] ts;
        logic [3:0]   us;
        aresetn = 1'b1; t_axis_tvalid = 1'b0; t_axis_tdata = '0;
        undef_axis_tdata = 1'b0; hit_axis_tready = 1'b1;
        #2 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_t_tready", 32'(t_axis_tready), 32'd0);
        chk("rst_hit_tvalid", 32'(hit_axis_tvalid), 32'd0);
        chk("rst_tdata", hit_axis_tdata, PINF);
        chk("rst_obj", 32'(hit_axis_obj), 32'd0);
        chk("rst_miss", 32'(hit_axis_miss), 32'd1);
        @(posedge aclk); #1 aresetn = 1'b1;
        chk("rst_wait_tready", 32'(t_axis_tready), 32'd0);
        @(posedge aclk); #1;
        chk("post_rst_tready", 32'(t_axis_tready), 32'd1);

        // Basic reduction: 0.5 at index 1 wins; result visible right after beat 3.
        send_ray(RAY_BASIC, 4'b0100);
        check_result("basic", 32'h3f000000, 2'd1, 1'b0);
        @(posedge aclk); #1;
        chk("basic_after_hs_tvalid", 32'(hit_axis_tvalid), 32'd0);
        chk("basic_after_hs_tready", 32'(t_axis_tready), 32'd1);

        // Every beat rejected: undef, negative, below T_MIN, +inf.
        send_ray(RAY_REJ, 4'b0001);
        check_result("reject", PINF, 2'd0, 1'b1);
        wait_drain("reject_drain");

        // Equal distances keep index 0; T_MIN itself is not a candidate.
        send_ray(RAY_TIE, 4'b0000);
        check_result("tie", 32'h3f800000, 2'd0, 1'b0);
        wait_drain("tie_drain");

        // Backpressure: result holds for 5 cycles with input stalled.
        hit_axis_tready = 1'b0;
        send_ray(RAY_BASIC, 4'b0100);
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge aclk);
            check_result("bp_hold", 32'h3f000000, 2'd1, 1'b0);
            @(posedge aclk); #1;
        end
        hit_axis_tready = 1'b1;
        @(posedge aclk); #1;
        chk("bp_ready_after_hs", 32'(t_axis_tready), 32'd1);
        send_ray(RAY_TIE, 4'b0000);
        check_result("bp_next_ray", 32'h3f800000, 2'd0, 1'b0);
        wait_drain("bp_drain");

        // Random gaps and value classes over 100 rays.
        for (int unsigned r = 0; r < 100; r++) begin
            for (int unsigned i = 0; i < NOBJ; i++) begin
                logic [31:0] t;
                logic        u;
                u = 1'b0;
                case ($urandom_range(0, 9))
                    0: begin u = 1'b1; t = $urandom; end
                    1: t = {1'b1, 8'($urandom_range(100, 140)), 23'($urandom)};
                    2: t = {1'b0, 8'hff, 23'($urandom_range(0, 3))};
                    3: t = TMIN;
                    4: t = 32'h3f800000;
                    default: t = {1'b0, 8'($urandom_range(110, 135)), 23'($urandom)};
                endcase
                send_beat(t, u, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            end
        end
        wait_drain("random_drain");

        // Reset after two beats: partial ray is discarded.
        send_beat(32'h3c000000, 1'b0, 0);
        send_beat(32'h3c000000, 1'b0, 0);
        aresetn = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end
        chk("midrst_no_result", 32'(hit_axis_tvalid), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("midrst_tready", 32'(t_axis_tready), 32'd1);
        send_ray(RAY_RST, 4'b0000);
        check_result("midrst_ray", 32'h3e800000, 2'd0, 1'b0);
        wait_drain("midrst_drain");

        repeat (3) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
